// File: rtl/uart_word_receiver_if.sv
// Word-level result bundle of uart_word_receiver: assembled word, strobe,
// per-word error flags and the busy indication.
interface uart_word_receiver_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] Data;
  logic             Data_Ready;
  logic             Parity_ERR;
  logic             Frame_ERR;
  logic             Busy;

  modport master (output Data, Data_Ready, Parity_ERR, Frame_ERR, Busy);
  modport slave  (input  Data, Data_Ready, Parity_ERR, Frame_ERR, Busy);
endinterface

// File: rtl/uart_word_receiver.sv
// Oversampling UART receiver with 2-of-3 mid-bit voting, optional parity, and
// packing of WORD_BYTES characters (LSB byte first) into one parallel word.
module uart_word_receiver #(
  parameter int DATA_BITS    = 8,
  parameter int WORD_BYTES   = 4,
  parameter int PARITY       = 1,
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic CLK,
  input  logic CLR,
  input  logic CLK_Baud,
  input  logic Serial_input,
  uart_word_receiver_if.master rx_if
);

  localparam int WIDTH    = DATA_BITS * WORD_BYTES;
  localparam int IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TICK_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_BITS);
  localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic                 sync1_q, sync2_q, prev_q;
  logic [1:0]           vld_q;
  logic [2:0]           state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [WIDTH-1:0]     word_q, word_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic rx, start_det, vote, par_exp;
  logic at_s0, at_s1, at_vote, at_end;

  assign rx        = sync2_q;
  assign start_det = (state_q == ST_IDLE) && prev_q && !rx;
  assign at_s0     = CLK_Baud && (tick_q == TICK_W'(OVERSAMPLE/2 - 1));
  assign at_s1     = CLK_Baud && (tick_q == TICK_W'(OVERSAMPLE/2));
  assign at_vote   = CLK_Baud && (tick_q == TICK_W'(OVERSAMPLE/2 + 1));
  assign at_end    = CLK_Baud && (tick_q == TICK_W'(OVERSAMPLE - 1));
  assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx) | (samp_q[1] & rx);
  assign par_exp   = (^shift_q) ^ (PARITY == 2);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the case statement can leave it unassigned and infer a latch.
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    word_d     = word_q;
    idx_d      = idx_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    to_d       = to_q;
    data_d     = data_q;
    ready_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    if (state_q != ST_IDLE && CLK_Baud)
      tick_d = (tick_q == TICK_W'(OVERSAMPLE - 1)) ? '0 : tick_q + TICK_W'(1);
    if (at_s0) samp_d[0] = rx;
    if (at_s1) samp_d[1] = rx;

    case (state_q)
      ST_IDLE: begin
        // Start detection outranks a timeout expiring in the same cycle.
        if (start_det) begin
          state_d = ST_START;
          tick_d  = '0;
          to_d    = '0;
        end else if (idx_q == '0) begin
          to_d = '0;
        end else if (CLK_Baud) begin
          if (to_q == TO_W'(TO_LIMIT - 1)) begin
            idx_d      = '0;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
            to_d       = '0;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
      end
      ST_START: begin
        if (at_vote && vote) begin
          state_d = ST_IDLE;
        end else if (at_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (at_vote) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (at_vote && (vote != par_exp)) perr_acc_d = 1'b1;
        if (at_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Return to IDLE at the stop-bit vote so a back-to-back start edge is caught.
        if (at_vote) begin
          state_d = ST_IDLE;
          word_d[idx_q*DATA_BITS +: DATA_BITS] = shift_q;
          if (idx_q == IDX_W'(WORD_BYTES - 1)) begin
            data_d     = word_d;
            perr_d     = perr_acc_q;
            ferr_d     = ferr_acc_q | ~vote;
            ready_d    = 1'b1;
            idx_d      = '0;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            ferr_acc_d = ferr_acc_q | ~vote;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b0;
      vld_q      <= '0;
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      // NOTE: the word staging register is reset like any other state; it is
      // small and a clean reset keeps discarded partial words from resurfacing.
      word_q     <= '0;
      idx_q      <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      to_q       <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      sync1_q    <= Serial_input;
      sync2_q    <= sync1_q;
      vld_q      <= {vld_q[0], 1'b1};
      // prev_q only carries a real line level, so a low line at reset release is no edge.
      prev_q     <= vld_q[1] ? sync2_q : 1'b0;
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      to_q       <= to_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_if.Data       = data_q;
  assign rx_if.Data_Ready = ready_q;
  assign rx_if.Parity_ERR = perr_q;
  assign rx_if.Frame_ERR  = ferr_q;
  assign rx_if.Busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_word_receiver.sv
// Directed bench for uart_word_receiver at defaults (8 data bits, 4 bytes,
// even parity, 16x oversampling, 20-bit timeout).
module tb_uart_word_receiver;

  localparam int OS = 16;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [3:0]  flip;
    logic [3:0]  bad_stop;
    logic [3:0]  glitch;
    logic [31:0] exp_data;
    logic        exp_p;
    logic        exp_f;
  } vec_t;

  logic clk = 1'b0;
  logic clr;
  logic clk_baud = 1'b0;
  logic ser;
  int   bcnt = 0;
  int   checks = 0;
  int   failures = 0;
  int   ready_cnt = 0;

  uart_word_receiver_if #(.WIDTH(32)) rx_if ();

  uart_word_receiver dut (
    .CLK          (clk),
    .CLR          (clr),
    .CLK_Baud     (clk_baud),
    .Serial_input (ser),
    .rx_if        (rx_if)
  );

  always #5 clk = ~clk;

  // One baud tick every 4 CLK, changing on the falling edge.
  always @(negedge clk) begin
    bcnt = bcnt + 1;
    clk_baud = (bcnt % 4 == 0);
  end

  always @(negedge clk) if (rx_if.Data_Ready === 1'b1) ready_cnt = ready_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (clk_baud !== 1'b1);
    #1;
  endtask

  task automatic put_tick(input logic v);
    ser = v;
    wait_tick();
  endtask

  task automatic send_char(input logic [7:0] b, input logic flip, input logic bad, input logic glitch);
    logic [10:0] frame;
    frame = {1'b1, (^b) ^ flip, b, 1'b0};
    for (int n = 0; n < 11; n++) begin
      for (int j = 0; j < OS; j++) begin
        logic v;
        v = frame[n];
        if (glitch && n == 3 && j == OS/2) v = ~v;
        if (bad && n == 10) v = (j >= 12);
        put_tick(v);
      end
    end
  endtask

  task automatic idle_bits(input int nbits);
    for (int i = 0; i < nbits * OS; i++) put_tick(1'b1);
  endtask

  vec_t vecs[7];
  int   r0;

  initial begin
    vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 4'b0000, 4'b0000, 4'b0000, 32'h44332211, 1'b0, 1'b0};
    vecs[1] = '{8'h11, 8'h22, 8'h33, 8'h44, 4'b0010, 4'b0000, 4'b0000, 32'h44332211, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 8'h22, 8'h33, 8'h44, 4'b0000, 4'b0000, 4'b0000, 32'h44332211, 1'b0, 1'b0};
    vecs[3] = '{8'h5A, 8'hA5, 8'h00, 8'hFF, 4'b0000, 4'b0100, 4'b0000, 32'hFF00A55A, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 8'h80, 8'h7E, 8'h81, 4'b0000, 4'b0000, 4'b0000, 32'h817E8001, 1'b0, 1'b0};
    vecs[5] = '{8'hC3, 8'h3C, 8'h96, 8'h69, 4'b0000, 4'b0000, 4'b1111, 32'h69963CC3, 1'b0, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 8'h56, 8'h78, 4'b0001, 4'b1000, 4'b0000, 32'h78563412, 1'b1, 1'b1};

    // Reset with the line held low: release must not look like a start edge.
    clr = 1'b0;
    ser = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_data",  {32'h0, rx_if.Data}, 64'h0);
    check("reset_flags", {61'h0, rx_if.Parity_ERR, rx_if.Frame_ERR, rx_if.Busy}, 64'h0);
    clr = 1'b1;
    repeat (20) wait_tick();
    check("low_at_release_busy", {63'h0, rx_if.Busy}, 64'h0);
    ser = 1'b1;
    idle_bits(2);

    for (int i = 0; i < 7; i++) begin
      r0 = ready_cnt;
      wait_tick();
      send_char(vecs[i].b0, vecs[i].flip[0], vecs[i].bad_stop[0], vecs[i].glitch[0]);
      send_char(vecs[i].b1, vecs[i].flip[1], vecs[i].bad_stop[1], vecs[i].glitch[1]);
      send_char(vecs[i].b2, vecs[i].flip[2], vecs[i].bad_stop[2], vecs[i].glitch[2]);
      send_char(vecs[i].b3, vecs[i].flip[3], vecs[i].bad_stop[3], vecs[i].glitch[3]);
      check($sformatf("v%0d_ready_count", i), 64'(ready_cnt - r0), 64'd1);
      check($sformatf("v%0d_data", i), {32'h0, rx_if.Data}, {32'h0, vecs[i].exp_data});
      check($sformatf("v%0d_parity_err", i), {63'h0, rx_if.Parity_ERR}, {63'h0, vecs[i].exp_p});
      check($sformatf("v%0d_frame_err", i), {63'h0, rx_if.Frame_ERR}, {63'h0, vecs[i].exp_f});
    end

    // False start: line low for 4 ticks only.
    r0 = ready_cnt;
    wait_tick();
    put_tick(1'b0);
    put_tick(1'b0);
    check("false_start_busy_high", {63'h0, rx_if.Busy}, 64'h1);
    put_tick(1'b0);
    put_tick(1'b0);
    for (int j = 0; j < OS; j++) put_tick(1'b1);
    check("false_start_busy_low", {63'h0, rx_if.Busy}, 64'h0);
    check("false_start_no_ready", 64'(ready_cnt - r0), 64'd0);
    idle_bits(1);

    // Short idle inside a word keeps the partial word.
    r0 = ready_cnt;
    wait_tick();
    send_char(8'hAA, 1'b0, 1'b0, 1'b0);
    send_char(8'hBB, 1'b0, 1'b0, 1'b0);
    idle_bits(10);
    send_char(8'h01, 1'b0, 1'b0, 1'b0);
    send_char(8'h02, 1'b0, 1'b0, 1'b0);
    check("short_idle_ready_count", 64'(ready_cnt - r0), 64'd1);
    check("short_idle_data", {32'h0, rx_if.Data}, 64'h0201BBAA);

    // Long idle discards the partial word.
    r0 = ready_cnt;
    wait_tick();
    send_char(8'hAA, 1'b0, 1'b0, 1'b0);
    send_char(8'hBB, 1'b0, 1'b0, 1'b0);
    idle_bits(25);
    check("timeout_no_ready", 64'(ready_cnt - r0), 64'd0);
    send_char(8'h01, 1'b0, 1'b0, 1'b0);
    send_char(8'h02, 1'b0, 1'b0, 1'b0);
    send_char(8'h03, 1'b0, 1'b0, 1'b0);
    send_char(8'h04, 1'b0, 1'b0, 1'b0);
    check("timeout_ready_count", 64'(ready_cnt - r0), 64'd1);
    check("timeout_data", {32'h0, rx_if.Data}, 64'h04030201);

    // Reset in the middle of the second character.
    wait_tick();
    send_char(8'h55, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3 * OS + 5; j++) put_tick(j < OS ? 1'b0 : j[4]);
    check("pre_reset_busy", {63'h0, rx_if.Busy}, 64'h1);
    clr = 1'b0;
    #1;
    check("midreset_data", {32'h0, rx_if.Data}, 64'h0);
    check("midreset_flags", {60'h0, rx_if.Data_Ready, rx_if.Parity_ERR, rx_if.Frame_ERR, rx_if.Busy}, 64'h0);
    ser = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b1;
    idle_bits(1);
    r0 = ready_cnt;
    send_char(8'hDE, 1'b0, 1'b0, 1'b0);
    send_char(8'hAD, 1'b0, 1'b0, 1'b0);
    send_char(8'hBE, 1'b0, 1'b0, 1'b0);
    send_char(8'hEF, 1'b0, 1'b0, 1'b0);
    check("post_reset_ready_count", 64'(ready_cnt - r0), 64'd1);
    check("post_reset_data", {32'h0, rx_if.Data}, 64'hEFBEADDE);
    check("post_reset_flags", {62'h0, rx_if.Parity_ERR, rx_if.Frame_ERR}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
